rw_write_arbiter: RTL and testbench

RW_WRITE_ARBITER -- requirements
Module: rw_write_arbiter

---
 rtl/rw_write_arbiter_pkg.sv | 28 ++
 rtl/fifo.sv | 57 +++++
 rtl/rw_write_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_rw_write_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rw_write_arbiter_pkg.sv
// Shared types and register map for the write arbiter: id/register-bus types,
// status/perf register addresses and a saturating increment helper.
package swarm;

    typedef logic [7:0] id_t;

    // Register request: single-cycle write (aw*) and read (ar*) strobes.
    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic        awvalid;
        logic [31:0] awaddr;
    } reg_bus_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
    } reg_rsp_t;

    localparam logic [31:0] RW_ARB_STATUS = 32'h0000_0000;
    localparam logic [31:0] RW_ARB_GRANTS = 32'h0000_0004;
    localparam logic [31:0] RW_ARB_STALLS = 32'h0000_0008;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO of 2**LOG_DEPTH entries with occupancy count; push on full
// and pop on empty are ignored. LOG_DEPTH must be at least 1.
module fifo #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned LOG_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  logic [WIDTH-1:0]     din,
    input  logic                 pop,
    output logic [WIDTH-1:0]     dout,
    output logic                 full,
    output logic                 empty,
    output logic [LOG_DEPTH:0]   count
);

    localparam int unsigned DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH:0]   cnt;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (LOG_DEPTH+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = cnt;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + LOG_DEPTH'(1);
            end
            cnt <= cnt + (LOG_DEPTH+1)'(do_push) - (LOG_DEPTH+1)'(do_pop);
        end
    end

    // Storage needs no reset: reads are only meaningful when not empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/rw_write_arbiter.sv
// Round-robin arbiter of N_PORTS write requesters onto one registered write port,
// with in-order acknowledge routing. Define RW_WRITE_ARB_PERF_EN for grant/stall counters.
module rw_write_arbiter
    import swarm::*;
#(
    parameter int unsigned N_PORTS         = 2,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                 clk,
    input  logic                 rstn,

    input  logic [N_PORTS-1:0]   s_wvalid,
    output logic [N_PORTS-1:0]   s_wready,
    input  logic [31:0]          s_waddr [N_PORTS],
    input  logic [511:0]         s_wdata [N_PORTS],
    input  logic [63:0]          s_wstrb [N_PORTS],
    input  id_t                  s_wid   [N_PORTS],

    output logic [N_PORTS-1:0]   s_bvalid,
    input  logic [N_PORTS-1:0]   s_bready,
    output id_t                  s_bid,

    output logic                 m_wvalid,
    input  logic                 m_wready,
    output logic [31:0]          m_waddr,
    output logic [511:0]         m_wdata,
    output logic [63:0]          m_wstrb,
    output id_t                  m_wid,

    input  logic                 m_bvalid,
    input  id_t                  m_bid,
    output logic                 m_bready,

    input  reg_bus_t             reg_bus,
    output reg_rsp_t             reg_rsp
);

    localparam int unsigned IDX_W     = $clog2(N_PORTS);
    localparam int unsigned LOG_DEPTH = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W     = LOG_DEPTH + 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic             grant_any;
    logic             load_en;
    logic             room;
    logic             accept;

    logic [IDX_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] outstanding;
    logic             pop;

    logic             err_unexpected_b;
    logic             rd_valid;
    logic [31:0]      rd_data;
    logic [31:0]      rd_mux;
    logic [31:0]      status_word;

    // Round-robin search: walk from the far end back to rr_ptr so the requester
    // closest to rr_ptr is the last (and winning) assignment.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        winner    = rr_ptr;
        grant_any = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int k = int'(N_PORTS) - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= int'(N_PORTS)) begin
                idx = idx - int'(N_PORTS);
            end
            cand = IDX_W'(idx);
            if (s_wvalid[cand]) begin
                winner    = cand;
                grant_any = 1'b1;
            end
        end
    end

    assign load_en  = ~m_wvalid | m_wready;
    assign room     = (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign accept   = rstn & grant_any & load_en & room;
    assign s_wready = accept ? (N_PORTS'(1) << winner) : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr   <= '0;
            m_wvalid <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr   <= (winner == IDX_W'(N_PORTS - 1)) ? '0 : winner + IDX_W'(1);
                m_wvalid <= 1'b1;
            end else if (m_wready) begin
                m_wvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            m_waddr <= s_waddr[winner];
            m_wdata <= s_wdata[winner];
            m_wstrb <= s_wstrb[winner];
            m_wid   <= s_wid[winner];
        end
    end

    // Issue order of requesters; acknowledges are steered to the head entry.
    fifo #(
        .WIDTH     (IDX_W),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_order_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (accept),
        .din   (winner),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

    always_comb begin
        s_bvalid = '0;
        m_bready = 1'b0;
        if (rstn) begin
            if (fifo_empty) begin
                // Unexpected response: swallow it.
                m_bready = m_bvalid;
            end else begin
                s_bvalid[head] = m_bvalid;
                m_bready       = s_bready[head];
            end
        end
    end

    assign s_bid = m_bid;
    assign pop   = m_bvalid & m_bready & ~fifo_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_unexpected_b <= 1'b0;
        end else if (m_bvalid && fifo_empty) begin
            err_unexpected_b <= 1'b1;
        end
    end

`ifdef RW_WRITE_ARB_PERF_EN
    logic [31:0] grants;
    logic [31:0] stalls;
    logic        perf_clr;

    assign perf_clr = reg_bus.awvalid &&
                      (reg_bus.awaddr == RW_ARB_GRANTS || reg_bus.awaddr == RW_ARB_STALLS);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grants <= '0;
            stalls <= '0;
        end else if (perf_clr) begin
            grants <= '0;
            stalls <= '0;
        end else begin
            if (accept) begin
                grants <= sat_inc32(grants);
            end
            if (|s_wvalid && !accept) begin
                stalls <= sat_inc32(stalls);
            end
        end
    end
`endif

    assign status_word = 32'({err_unexpected_b, outstanding});

    always_comb begin
        rd_mux = '0;
        case (reg_bus.araddr)
            RW_ARB_STATUS: rd_mux = status_word;
`ifdef RW_WRITE_ARB_PERF_EN
            RW_ARB_GRANTS: rd_mux = grants;
            RW_ARB_STALLS: rd_mux = stalls;
`endif
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= reg_bus.arvalid;
            if (reg_bus.arvalid) begin
                rd_data <= rd_mux;
            end
        end
    end

    assign reg_rsp.rvalid = rd_valid;
    assign reg_rsp.rdata  = rd_data;

    a_wready_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(s_wready));
    a_bvalid_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(s_bvalid));

endmodule

// File: tb/tb_rw_write_arbiter.sv
// Directed bench for rw_write_arbiter (N_PORTS=2, MAX_OUTSTANDING=8); expected
// values are hand-derived and adapt to RW_WRITE_ARB_PERF_EN.
module tb_rw_write_arbiter;
    import swarm::*;

    localparam int unsigned CNT_W = 4;
`ifdef RW_WRITE_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [1:0]   s_wvalid;
    logic [1:0]   s_wready;
    logic [31:0]  s_waddr [2];
    logic [511:0] s_wdata [2];
    logic [63:0]  s_wstrb [2];
    id_t          s_wid   [2];
    logic [1:0]   s_bvalid;
    logic [1:0]   s_bready;
    id_t          s_bid;
    logic         m_wvalid;
    logic         m_wready;
    logic [31:0]  m_waddr;
    logic [511:0] m_wdata;
    logic [63:0]  m_wstrb;
    id_t          m_wid;
    logic         m_bvalid;
    id_t          m_bid;
    logic         m_bready;
    reg_bus_t     reg_bus;
    reg_rsp_t     reg_rsp;

    int n_tests = 0;
    int n_fail  = 0;

    rw_write_arbiter #(
        .N_PORTS         (2),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_wvalid (s_wvalid),
        .s_wready (s_wready),
        .s_waddr  (s_waddr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_wid    (s_wid),
        .s_bvalid (s_bvalid),
        .s_bready (s_bready),
        .s_bid    (s_bid),
        .m_wvalid (m_wvalid),
        .m_wready (m_wready),
        .m_waddr  (m_waddr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_wid    (m_wid),
        .m_bvalid (m_bvalid),
        .m_bid    (m_bid),
        .m_bready (m_bready),
        .reg_bus  (reg_bus),
        .reg_rsp  (reg_rsp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        s_wvalid        = '0;
        s_bready        = '0;
        m_wready        = 1'b0;
        m_bvalid        = 1'b0;
        m_bid           = '0;
        reg_bus.arvalid = 1'b0;
        reg_bus.araddr  = '0;
        reg_bus.awvalid = 1'b0;
        reg_bus.awaddr  = '0;
    endtask

    task automatic set_port(input int p, input logic [7:0] id);
        s_wid[p]   = id;
        s_waddr[p] = 32'h1000 + {24'h0, id};
        s_wdata[p] = {8{56'hA5A5_0000_0000_00, id}};
        s_wstrb[p] = '1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        cycle();
        cycle();
        rstn = 1'b1;
    endtask

    task automatic reg_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        reg_bus.arvalid = 1'b1;
        reg_bus.araddr  = addr;
        settle();
        check_eq({tag, "_rvalid_early"}, reg_rsp.rvalid, 1'b0);
        cycle();
        reg_bus.arvalid = 1'b0;
        settle();
        check_eq({tag, "_rvalid"}, reg_rsp.rvalid, 1'b1);
        check_eq(tag, reg_rsp.rdata, exp);
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_bv;
        idle_inputs();
        set_port(0, 8'h00);
        set_port(1, 8'h01);

        // Reset: outputs quiet even with live inputs.
        s_wvalid = 2'b11;
        m_bvalid = 1'b1;
        m_wready = 1'b1;
        s_bready = 2'b11;
        settle();
        check_eq("rst_wready", s_wready, 2'b00);
        check_eq("rst_bvalid", s_bvalid, 2'b00);
        check_eq("rst_mbready", m_bready, 1'b0);
        check_eq("rst_mwvalid", m_wvalid, 1'b0);
        cycle();
        cycle();
        check_eq("rst_mwvalid2", m_wvalid, 1'b0);
        idle_inputs();
        rstn = 1'b1;
        reg_read("rst_status", RW_ARB_STATUS, 32'h0);

        // Two requesters always valid: alternate grants, one per cycle.
        set_port(0, 8'h10);
        set_port(1, 8'h11);
        s_wvalid = 2'b11;
        m_wready = 1'b1;
        settle();
        check_eq("rr_g0", s_wready, 2'b01);
        check_eq("rr_mw0", m_wvalid, 1'b0);
        cycle();
        settle();
        check_eq("rr_g1", s_wready, 2'b10);
        check_eq("rr_mw1", m_wvalid, 1'b1);
        check_eq("rr_id1", m_wid, 8'h10);
        cycle();
        settle();
        check_eq("rr_g2", s_wready, 2'b01);
        check_eq("rr_id2", m_wid, 8'h11);
        cycle();
        settle();
        check_eq("rr_g3", s_wready, 2'b10);
        check_eq("rr_id3", m_wid, 8'h10);
        cycle();
        s_wvalid = 2'b00;
        settle();
        check_eq("rr_id4", m_wid, 8'h11);
        check_eq("rr_addr4", m_waddr, 32'h1011);
        check_eq("rr_data4", m_wdata[63:0], 64'hA5A5_0000_0000_0011);
        cycle();
        check_eq("rr_drain", m_wvalid, 1'b0);
        reg_read("rr_status", RW_ARB_STATUS, 32'd4);

        // Acknowledges follow issue order 0,1,0,1.
        s_bready = 2'b11;
        m_bvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_bid  = 8'(8'h40 + k);
            exp_bv = k[0] ? 2'b10 : 2'b01;
            settle();
            check_eq("rr_bvalid", s_bvalid, exp_bv);
            check_eq("rr_bid", s_bid, 8'(8'h40 + k));
            check_eq("rr_mbready", m_bready, 1'b1);
            cycle();
        end
        m_bvalid = 1'b0;
        reg_read("rr_status_empty", RW_ARB_STATUS, 32'd0);

        // Backpressure on the write port holds the output register.
        do_reset();
        set_port(1, 8'h21);
        s_wvalid = 2'b10;
        settle();
        check_eq("bp_first", s_wready, 2'b10);
        cycle();
        set_port(1, 8'h22);
        for (int k = 0; k < 5; k++) begin
            settle();
            check_eq("bp_wready", s_wready, 2'b00);
            check_eq("bp_mwvalid", m_wvalid, 1'b1);
            check_eq("bp_mwid", m_wid, 8'h21);
            check_eq("bp_maddr", m_waddr, 32'h1021);
            cycle();
        end
        m_wready = 1'b1;
        settle();
        check_eq("bp_release", s_wready, 2'b10);
        cycle();
        s_wvalid = 2'b00;
        settle();
        check_eq("bp_mwid2", m_wid, 8'h22);
        check_eq("bp_idle", s_wready, 2'b00);
        cycle();
        check_eq("bp_drain", m_wvalid, 1'b0);
        reg_read("bp_status", RW_ARB_STATUS, 32'd2);

        // Outstanding limit: 8 in flight, 9th waits for one acknowledge.
        do_reset();
        m_wready = 1'b1;
        set_port(0, 8'h50);
        s_wvalid = 2'b01;
        for (int k = 0; k < 8; k++) begin
            settle();
            check_eq("lim_accept", s_wready, 2'b01);
            cycle();
        end
        settle();
        check_eq("lim_full", s_wready, 2'b00);
        cycle();
        settle();
        check_eq("lim_full_hold", s_wready, 2'b00);
        m_bvalid = 1'b1;
        m_bid    = 8'h50;
        s_bready = 2'b01;
        settle();
        check_eq("lim_pop_bvalid", s_bvalid, 2'b01);
        check_eq("lim_pop_mbready", m_bready, 1'b1);
        check_eq("lim_pop_nopush", s_wready, 2'b00);
        cycle();
        m_bvalid = 1'b0;
        settle();
        check_eq("lim_ninth", s_wready, 2'b01);
        cycle();
        s_wvalid = 2'b00;
        reg_read("lim_status", RW_ARB_STATUS, 32'd8);

        // Reset mid-transfer discards everything in flight.
        do_reset();
        check_eq("mid_rst_mwvalid", m_wvalid, 1'b0);
        reg_read("mid_rst_status", RW_ARB_STATUS, 32'd0);

        // Issue order 1,0,1; acknowledges routed in that order with stall on port 1.
        m_wready = 1'b1;
        set_port(1, 8'h31);
        s_wvalid = 2'b10;
        settle();
        check_eq("ord_g0", s_wready, 2'b10);
        cycle();
        set_port(0, 8'h30);
        s_wvalid = 2'b01;
        settle();
        check_eq("ord_g1", s_wready, 2'b01);
        cycle();
        set_port(1, 8'h32);
        s_wvalid = 2'b10;
        settle();
        check_eq("ord_g2", s_wready, 2'b10);
        cycle();
        s_wvalid = 2'b00;
        m_bvalid = 1'b1;
        m_bid    = 8'h31;
        s_bready = 2'b10;
        settle();
        check_eq("ord_b0", s_bvalid, 2'b10);
        check_eq("ord_bid0", s_bid, 8'h31);
        check_eq("ord_mbr0", m_bready, 1'b1);
        cycle();
        m_bid    = 8'h30;
        s_bready = 2'b01;
        settle();
        check_eq("ord_b1", s_bvalid, 2'b01);
        check_eq("ord_bid1", s_bid, 8'h30);
        check_eq("ord_mbr1", m_bready, 1'b1);
        cycle();
        m_bid    = 8'h32;
        s_bready = 2'b00;
        settle();
        check_eq("ord_b2", s_bvalid, 2'b10);
        check_eq("ord_mbr_stall", m_bready, 1'b0);
        cycle();
        settle();
        check_eq("ord_b2_hold", s_bvalid, 2'b10);
        s_bready = 2'b10;
        settle();
        check_eq("ord_mbr2", m_bready, 1'b1);
        check_eq("ord_bid2", s_bid, 8'h32);
        cycle();
        m_bvalid = 1'b0;
        settle();
        check_eq("ord_b_done", s_bvalid, 2'b00);
        reg_read("ord_status", RW_ARB_STATUS, 32'd0);

        // Acknowledge with nothing outstanding: dropped, sticky error.
        m_bvalid = 1'b1;
        m_bid    = 8'h77;
        s_bready = 2'b00;
        settle();
        check_eq("unexp_mbready", m_bready, 1'b1);
        check_eq("unexp_bvalid", s_bvalid, 2'b00);
        cycle();
        m_bvalid = 1'b0;
        reg_read("unexp_status", RW_ARB_STATUS, 32'(1) << CNT_W);
        cycle();
        cycle();
        reg_read("unexp_sticky", RW_ARB_STATUS, 32'(1) << CNT_W);
        reg_read("unmapped", 32'h0000_0040, 32'h0);
        do_reset();
        reg_read("unexp_cleared", RW_ARB_STATUS, 32'h0);

        // Perf counters: 10 grants, 3 stall cycles, then clear by write.
        m_wready = 1'b1;
        s_bready = 2'b01;
        set_port(0, 8'h60);
        s_wvalid = 2'b01;
        repeat (5) cycle();
        s_wvalid = 2'b00;
        m_bvalid = 1'b1;
        repeat (5) cycle();
        m_bvalid = 1'b0;
        s_wvalid = 2'b01;
        repeat (5) cycle();
        m_wready = 1'b0;
        repeat (3) cycle();
        s_wvalid = 2'b00;
        m_wready = 1'b1;
        reg_read("perf_status", RW_ARB_STATUS, 32'd5);
        reg_read("perf_grants", RW_ARB_GRANTS, PERF ? 32'd10 : 32'd0);
        reg_read("perf_stalls", RW_ARB_STALLS, PERF ? 32'd3 : 32'd0);
        reg_bus.awvalid = 1'b1;
        reg_bus.awaddr  = RW_ARB_STALLS;
        cycle();
        reg_bus.awvalid = 1'b0;
        reg_read("perf_grants_clr", RW_ARB_GRANTS, 32'd0);
        reg_read("perf_stalls_clr", RW_ARB_STALLS, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
